// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle 8-bit unsigned multiplier / divider.
//
// One iteration per clock. Multiply uses shift-add, divide uses restoring
// division with a 9-bit partial-remainder subtract. Results stay on the
// output registers until the next operation completes, so the select stage
// downstream always sees stable data.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   request pulse, sampled on clk in IDLE only
//   opcode  in   6-bit op code, OP_MUL or OP_DIV accepted, others ignored
//   x       in   multiplicand / dividend
//   y       in   multiplier / divisor
//   bh, bl  out  product high / low byte
//   ch, cl  out  remainder / quotient
//   busy    out  operation in progress
//   done    out  one-cycle pulse, results updated
//   div0    out  last divide had y == 0
module muldiv_seq #(
    parameter logic [5:0]  OP_MUL = 6'b000010,
    parameter logic [5:0]  OP_DIV = 6'b000100,
    parameter int unsigned ITER   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] bh,
    output logic [7:0] bl,
    output logic [7:0] ch,
    output logic [7:0] cl,
    output logic       busy,
    output logic       done,
    output logic       div0
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [2:0] LastCnt = 3'(ITER - 1);

    state_e      state;
    logic [2:0]  cnt;
    logic        is_div;
    // Operand used by every iteration: multiplicand for mul, divisor for div.
    logic [7:0]  opnd;
    // Shared working register.
    //   mul: {partial product high, remaining multiplier / product low bits}
    //   div: {partial remainder, dividend bits still to shift in / quotient}
    logic [15:0] acc;
    logic [15:0] acc_step;

    logic [8:0]  mul_sum;
    logic [8:0]  div_pr;
    logic [9:0]  div_diff;

    // One iteration of the selected algorithm.
    always_comb begin
        mul_sum  = {1'b0, acc[15:8]} + (acc[0] ? {1'b0, opnd} : 9'd0);
        div_pr   = {acc[15:8], acc[7]};
        div_diff = {1'b0, div_pr} - {2'b00, opnd};
        acc_step = acc;
        if (is_div) begin
            // Borrow clear means the divisor fits: keep the difference, shift in a 1.
            if (!div_diff[9]) begin
                acc_step = {div_diff[7:0], acc[6:0], 1'b1};
            end else begin
                acc_step = {div_pr[7:0], acc[6:0], 1'b0};
            end
        end else begin
            // Add-then-shift-right; the carry out of the add lands in bit 15.
            acc_step = {mul_sum, acc[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            cnt    <= 3'd0;
            is_div <= 1'b0;
            opnd   <= 8'h00;
            acc    <= 16'h0000;
            bh     <= 8'h00;
            bl     <= 8'h00;
            ch     <= 8'h00;
            cl     <= 8'h00;
            busy   <= 1'b0;
            done   <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start && (opcode == OP_MUL || opcode == OP_DIV)) begin
                        is_div <= (opcode == OP_DIV);
                        opnd   <= (opcode == OP_DIV) ? y : x;
                        acc    <= {8'h00, (opcode == OP_DIV) ? x : y};
                        cnt    <= 3'd0;
                        busy   <= 1'b1;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    acc <= acc_step;
                    cnt <= cnt + 3'd1;
                    if (cnt == LastCnt) begin
                        if (is_div) begin
                            ch   <= acc_step[15:8];
                            cl   <= acc_step[7:0];
                            div0 <= (opnd == 8'h00);
                        end else begin
                            bh <= acc_step[15:8];
                            bl <= acc_step[7:0];
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    localparam logic [5:0] OP_MUL = 6'b000010;
    localparam logic [5:0] OP_DIV = 6'b000100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [7:0] x = 8'd0;
    logic [7:0] y = 8'd0;
    logic [7:0] bh, bl, ch, cl;
    logic       busy, done, div0;

    int total = 0;
    int bad = 0;

    // Reference model of the result registers.
    logic [7:0] e_bh = 8'h00, e_bl = 8'h00, e_ch = 8'h00, e_cl = 8'h00;
    logic       e_div0 = 1'b0;

    muldiv_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .opcode (opcode),
        .x      (x),
        .y      (y),
        .bh     (bh),
        .bl     (bl),
        .ch     (ch),
        .cl     (cl),
        .busy   (busy),
        .done   (done),
        .div0   (div0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp_pair;  // {bh,bl} for mul, {ch,cl} for div
        logic        exp_div0;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_op(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        int p;
        if (op == OP_MUL) begin
            p = int'(a) * int'(b);
            e_bh = p[15:8];
            e_bl = p[7:0];
        end else if (op == OP_DIV) begin
            if (b == 0) begin
                e_cl = 8'hFF;
                e_ch = a;
                e_div0 = 1'b1;
            end else begin
                e_cl = 8'(int'(a) / int'(b));
                e_ch = 8'(int'(a) % int'(b));
                e_div0 = 1'b0;
            end
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".bh"}, 32'(bh), 32'(e_bh));
        check({tag, ".bl"}, 32'(bl), 32'(e_bl));
        check({tag, ".ch"}, 32'(ch), 32'(e_ch));
        check({tag, ".cl"}, 32'(cl), 32'(e_cl));
        check({tag, ".div0"}, 32'(div0), 32'(e_div0));
    endtask

    // Issue one operation, scramble the inputs after acceptance, measure
    // the busy window and verify the outputs held until completion.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [7:0] a,
                          input logic [7:0] b);
        int lat;
        bit stable;
        logic [32:0] prev;
        @(negedge clk);
        opcode = op; x = a; y = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x = 8'($urandom); y = 8'($urandom); opcode = 6'($urandom);
        prev = {bh, bl, ch, cl, div0};
        lat = 0;
        stable = 1'b1;
        while (!done && lat < 20) begin
            if (busy) lat++;
            else lat = 100;
            if ({bh, bl, ch, cl, div0} !== prev) stable = 1'b0;
            @(negedge clk);
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy_cycles"}, 32'(lat), 32'd8);
        check({tag, ".hold"}, 32'(stable), 32'd1);
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        model_op(op, a, b);
        check_outs(tag);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int ndone;
        logic [5:0] rop;
        logic [7:0] ra, rb;

        vecs[0] = '{OP_MUL, 8'd13,   8'd11,  16'h008F, 1'b0};
        vecs[1] = '{OP_MUL, 8'd255,  8'd255, 16'hFE01, 1'b0};
        vecs[2] = '{OP_MUL, 8'd0,    8'd200, 16'h0000, 1'b0};
        vecs[3] = '{OP_DIV, 8'd200,  8'd7,   16'h041C, 1'b0};
        vecs[4] = '{OP_DIV, 8'h5A,   8'd0,   16'h5AFF, 1'b1};
        vecs[5] = '{OP_DIV, 8'd9,    8'd3,   16'h0003, 1'b0};

        // Reset state
        #12;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
            if (vecs[i].op == OP_MUL)
                check($sformatf("vec%0d.pair", i), 32'({bh, bl}), 32'(vecs[i].exp_pair));
            else begin
                check($sformatf("vec%0d.pair", i), 32'({ch, cl}), 32'(vecs[i].exp_pair));
                check($sformatf("vec%0d.d0", i), 32'(div0), 32'(vecs[i].exp_div0));
            end
        end

        // Start while busy is ignored; start in DONE is ignored too.
        @(negedge clk);
        opcode = OP_MUL; x = 8'd6; y = 8'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        opcode = OP_DIV; x = 8'd100; y = 8'd10; start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            if (done) begin
                ndone++;
                model_op(OP_MUL, 8'd6, 8'd7);
                check("busyreq.pair", 32'({bh, bl}), 32'h002A);
                check_outs("busyreq");
                // Request during the DONE cycle.
                opcode = OP_MUL; x = 8'd2; y = 8'd2; start = 1'b1;
                @(negedge clk); start = 1'b0;
                check("donereq.busy", 32'(busy), 32'd0);
            end else begin
                @(negedge clk);
            end
        end
        check("busyreq.ndone", 32'(ndone), 32'd1);

        // Invalid opcode ignored
        @(negedge clk);
        opcode = 6'b000001; x = 8'd3; y = 8'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy || done) ndone++;
            @(negedge clk);
        end
        check("badop.activity", 32'(ndone), 32'd0);
        check_outs("badop");

        // Random operations against the model
        for (int i = 0; i < 30; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op($sformatf("rnd%0d", i), rop, ra, rb);
        end

        // Reset mid-operation
        @(negedge clk);
        opcode = OP_MUL; x = 8'd255; y = 8'd255; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        e_bh = 0; e_bl = 0; e_ch = 0; e_cl = 0; e_div0 = 0;
        check("midrst.busy", 32'(busy), 32'd0);
        check_outs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("midrst.no_done", 32'(ndone), 32'd0);
        run_op("post_rst", OP_MUL, 8'd3, 8'd5);
        check("post_rst.bl", 32'(bl), 32'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
